// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: active-low glyphs (bit 6 = segment a), BCD sizing and converter states
package sevenseg_pkg;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  function automatic int bcd_digits(input int w);
    return (w + 2) / 3;
  endfunction
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction
endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// sevenseg_scan_driver_if: write-only display bus; wr_dp exists only with SEVSEG_DP_EN
interface sevenseg_scan_driver_if #(
  parameter int DATA_W = 16
`ifdef SEVSEG_DP_EN
  ,
  parameter int NUM_DIGITS = 4
`endif
);
  logic wr_en;
  logic wr_hex;
  logic wr_blank;
  logic busy;
  logic [DATA_W-1:0] wr_data;
`ifdef SEVSEG_DP_EN
  logic [NUM_DIGITS-1:0] wr_dp;
`endif
  modport master (
    output wr_en, wr_data, wr_hex, wr_blank,
`ifdef SEVSEG_DP_EN
    output wr_dp,
`endif
    input busy
  );
  modport slave (
    input wr_en, wr_data, wr_hex, wr_blank,
`ifdef SEVSEG_DP_EN
    input wr_dp,
`endif
    output busy
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, DATA_W shift cycles then one load-strobe cycle and a DONE cycle
module bin2bcd_seq
  import sevenseg_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DATA_W-1:0] data,
  output logic busy,
  output logic done,
  output logic [4*bcd_digits(DATA_W)-1:0] bcd
);
  localparam int BD = bcd_digits(DATA_W);
  localparam int CW = $clog2(DATA_W + 1);
  conv_state_t state, state_n;
  logic [DATA_W-1:0] bin;
  logic [CW-1:0] cnt;
  logic [4*BD-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BD; i++) adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // done strobes in the last SHIFT cycle, once all DATA_W shifts have landed in bcd
  always_comb begin
    busy = state != IDLE;
    done = state == SHIFT && cnt == CW'(DATA_W);
    state_n = state == IDLE ? (start ? SHIFT : IDLE) : state == SHIFT ? (done ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bin <= '0;
      bcd <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        bin <= data;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT && !done) begin
        {bcd, bin} <= {adj, bin} << 1;
        cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: bus-writable multiplexed common-anode driver, hex or decimal with leading-zero blanking
// SEVSEG_DP_EN adds per-digit decimal points (bus wr_dp, output dp)
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W = 16,
  parameter int REFRESH_DIV = 262144
) (
  input  logic clk,
  input  logic rst,
  sevenseg_scan_driver_if.slave bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [0:6] seg
`ifdef SEVSEG_DP_EN
  ,
  output logic dp
`endif
);
  localparam int BD = bcd_digits(DATA_W);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  logic accept, conv_busy, conv_done, wrap, live, hex_mode, blank_mode, ovf, pend_blank, lz;
  logic [4*BD-1:0] bcd;
  logic [4*(BD+NUM_DIGITS)-1:0] bcd_pad;
  logic [4*NUM_DIGITS-1:0] digits, hex_vec;
  logic [3:0] cur;
  logic [6:0] glyph;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
`ifdef SEVSEG_DP_EN
  logic [NUM_DIGITS-1:0] dp_bits, pend_dp;
`endif
  bin2bcd_seq #(.DATA_W(DATA_W)) conv (
    .clk(clk),
    .rst(rst),
    .start(accept && !bus.wr_hex),
    .data(bus.wr_data),
    .busy(conv_busy),
    .done(conv_done),
    .bcd(bcd)
  );
  assign bus.busy = conv_busy;
  assign accept = bus.wr_en && !conv_busy;
  assign hex_vec = (4*NUM_DIGITS)'(bus.wr_data);
  assign bcd_pad = {{(4*NUM_DIGITS){1'b0}}, bcd};
  assign wrap = pre == PW'(REFRESH_DIV - 1);
  assign cur = digits[4*idx +: 4];
  // a digit is blanked when it and every digit above it are zero; digit 0 always shows
  assign lz = blank_mode && idx != '0 && (digits >> (4*idx)) == '0;
  assign glyph = !live ? SEG_BLANK : ovf && !hex_mode ? SEG_DASH : lz ? SEG_BLANK : seg_decode(cur);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      idx <= '0;
      live <= 1'b0;
      an <= '1;
      seg <= SEG_BLANK;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      idx <= !wrap ? idx : idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      live <= live || wrap;
      an <= live ? ~(NUM_DIGITS'(1) << idx) : '1;
      seg <= glyph;
    end
  // decimal writes park their mode bits until the converter's atomic load
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      digits <= '0;
      hex_mode <= 1'b0;
      blank_mode <= 1'b0;
      ovf <= 1'b0;
      pend_blank <= 1'b0;
`ifdef SEVSEG_DP_EN
      dp_bits <= '0;
      pend_dp <= '0;
`endif
    end else if (accept && bus.wr_hex) begin
      digits <= hex_vec;
      hex_mode <= 1'b1;
      blank_mode <= bus.wr_blank;
      ovf <= 1'b0;
`ifdef SEVSEG_DP_EN
      dp_bits <= bus.wr_dp;
`endif
    end else if (accept) begin
      pend_blank <= bus.wr_blank;
`ifdef SEVSEG_DP_EN
      pend_dp <= bus.wr_dp;
`endif
    end else if (conv_done) begin
      digits <= bcd_pad[4*NUM_DIGITS-1:0];
      hex_mode <= 1'b0;
      blank_mode <= pend_blank;
      ovf <= |(bcd_pad >> (4*NUM_DIGITS));
`ifdef SEVSEG_DP_EN
      dp_bits <= pend_dp;
`endif
    end
`ifdef SEVSEG_DP_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) dp <= 1'b1;
    else dp <= !(live && dp_bits[idx]);
`endif
endmodule
